mem_access_stage: RTL and testbench

- Memory-access stage of the RV32I core; sits between execute and write-back.
- Converts load/store control from execute into a request/acknowledge transaction on the data bus, with byte-lane strobes for stores and sign/zero extension for loads.
- Produces the memory_read_data consumed by write-back.
- Stalls the pipeline until the bus completes.

---
 rtl/mem_access_stage.sv | 123 ++++++++++++
 tb/tb_mem_access_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage of the RV32I core: turns execute-stage load/store control into a
// request/acknowledge bus transaction, with store byte lanes and load extension.
module mem_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] reg2_data,
  input  logic                  memory_read_enable,
  input  logic                  memory_write_enable,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] memory_read_data,
  output logic                  mem_done,
  output logic                  ctrl_stall_flag,
  output logic                  bus_request,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_write,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  output logic [3:0]            bus_write_strobe,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_read_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_reg, state_next;
  logic [2:0] funct3_reg;
  logic [1:0] offset_reg;

  logic mem_op, accept, complete;
  logic [DATA_WIDTH-1:0] store_data;
  logic [3:0]            store_strobe;
  logic [DATA_WIDTH-1:0] load_value;
  logic [7:0]            lane_byte [4];
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;

  assign mem_op   = ex_valid & (memory_read_enable | memory_write_enable);
  assign accept   = (state_reg == IDLE) & mem_op;
  assign complete = (state_reg == ACCESS) & bus_ack;

  // The completion cycle releases the pipeline even if the next mem op is already waiting.
  assign ctrl_stall_flag = (state_reg == ACCESS) | (mem_op & ~mem_done);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_op) state_next = ACCESS;
      ACCESS:  if (bus_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    store_data   = reg2_data;
    store_strobe = 4'b1111;
    case (funct3)
      3'b000: begin
        store_data   = {4{reg2_data[7:0]}};
        store_strobe = 4'b0001 << alu_result[1:0];
      end
      3'b001: begin
        store_data   = {2{reg2_data[15:0]}};
        store_strobe = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_byte[gi] = bus_read_data[8*gi +: 8];
  end

  assign sel_byte = lane_byte[offset_reg];
  assign sel_half = offset_reg[1] ? bus_read_data[31:16] : bus_read_data[15:0];

  always_comb begin
    load_value = bus_read_data;
    case (funct3_reg)
      3'b000:  load_value = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_value = {24'b0, sel_byte};
      3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_value = {16'b0, sel_half};
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      funct3_reg       <= '0;
      offset_reg       <= '0;
      memory_read_data <= '0;
      mem_done         <= 1'b0;
      bus_request      <= 1'b0;
      bus_address      <= '0;
      bus_write        <= 1'b0;
      bus_write_data   <= '0;
      bus_write_strobe <= '0;
    end else begin
      state_reg <= state_next;
      mem_done  <= 1'b0;
      if (accept) begin
        // Store wins when both enables are set.
        bus_request      <= 1'b1;
        bus_address      <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
        bus_write        <= memory_write_enable;
        bus_write_data   <= memory_write_enable ? store_data : '0;
        bus_write_strobe <= memory_write_enable ? store_strobe : 4'b0000;
        funct3_reg       <= funct3;
        offset_reg       <= alu_result[1:0];
      end else if (complete) begin
        bus_request <= 1'b0;
        mem_done    <= 1'b1;
        if (!bus_write) memory_read_data <= load_value;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a scoreboard queue holds each op's expected bus
// transaction and result, checked when the DUT presents the request and completes.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic [31:0] reg2_data;
  logic        memory_read_enable;
  logic        memory_write_enable;
  logic [2:0]  funct3;
  logic [31:0] memory_read_data;
  logic        mem_done;
  logic        ctrl_stall_flag;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_write_strobe;
  logic        bus_ack;
  logic [31:0] bus_read_data;

  always #5 clock = ~clock;

  mem_access_stage dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .ex_valid            (ex_valid),
    .alu_result          (alu_result),
    .reg2_data           (reg2_data),
    .memory_read_enable  (memory_read_enable),
    .memory_write_enable (memory_write_enable),
    .funct3              (funct3),
    .memory_read_data    (memory_read_data),
    .mem_done            (mem_done),
    .ctrl_stall_flag     (ctrl_stall_flag),
    .bus_request         (bus_request),
    .bus_address         (bus_address),
    .bus_write           (bus_write),
    .bus_write_data      (bus_write_data),
    .bus_write_strobe    (bus_write_strobe),
    .bus_ack             (bus_ack),
    .bus_read_data       (bus_read_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic done_cycle = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid            = 1'b0;
    memory_read_enable  = 1'b0;
    memory_write_enable = 1'b0;
    funct3              = 3'b000;
    alu_result          = 32'h0;
    reg2_data           = 32'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    32'(bus_request), 32'h0);
    chk({tag, "_addr"},   bus_address, 32'h0);
    chk({tag, "_wr"},     32'(bus_write), 32'h0);
    chk({tag, "_wdata"},  bus_write_data, 32'h0);
    chk({tag, "_strobe"}, 32'(bus_write_strobe), 32'h0);
    chk({tag, "_rdata"},  memory_read_data, 32'h0);
    chk({tag, "_done"},   32'(mem_done), 32'h0);
    chk({tag, "_stall"},  32'(ctrl_stall_flag), 32'h0);
  endtask

  // Called at a negedge; returns at the negedge of the mem_done cycle with inputs idle.
  task automatic do_op(input string tag, input logic wr, input logic rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] r2, input logic [31:0] bus_rd,
                       input int ack_delay, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_strobe,
                       input logic [31:0] exp_rdata);
    exp_t e;
    exp_t got;
    ex_valid            = 1'b1;
    memory_write_enable = wr;
    memory_read_enable  = rd;
    funct3              = f3;
    alu_result          = addr;
    reg2_data           = r2;
    e.addr   = exp_addr;
    e.wr     = wr;
    e.wdata  = exp_wdata;
    e.strobe = exp_strobe;
    e.rdata  = exp_rdata;
    sb.push_back(e);
    #1;
    chk({tag, "_stall_accept"}, 32'(ctrl_stall_flag), 32'(!done_cycle));
    @(posedge clock);
    done_cycle = 1'b0;
    @(negedge clock);
    idle_inputs();
    got = sb.pop_front();
    for (int i = 0; i <= ack_delay; i++) begin
      chk({tag, "_req"},    32'(bus_request), 32'h1);
      chk({tag, "_addr"},   bus_address, got.addr);
      chk({tag, "_wr"},     32'(bus_write), 32'(got.wr));
      chk({tag, "_wdata"},  bus_write_data, got.wdata);
      chk({tag, "_strobe"}, 32'(bus_write_strobe), 32'(got.strobe));
      chk({tag, "_stall"},  32'(ctrl_stall_flag), 32'h1);
      chk({tag, "_nodone"}, 32'(mem_done), 32'h0);
      if (i == ack_delay) begin
        bus_ack       = 1'b1;
        bus_read_data = bus_rd;
      end else begin
        bus_read_data = $urandom;
      end
      @(posedge clock);
      @(negedge clock);
    end
    bus_ack       = 1'b0;
    bus_read_data = $urandom;
    chk({tag, "_done"},      32'(mem_done), 32'h1);
    chk({tag, "_stall_done"}, 32'(ctrl_stall_flag), 32'h0);
    chk({tag, "_req_drop"},  32'(bus_request), 32'h0);
    chk({tag, "_rdata"},     memory_read_data, got.rdata);
    done_cycle = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus_ack       = 1'b0;
    bus_read_data = 32'h0;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Stray ack while idle must be ignored.
    bus_ack = 1'b1;
    bus_read_data = 32'hFFFF_FFFF;
    @(posedge clock);
    @(negedge clock);
    bus_ack = 1'b0;
    chk("idle_ack_done", 32'(mem_done), 32'h0);
    chk("idle_ack_req", 32'(bus_request), 32'h0);

    do_op("lb",  1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
          32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_FF80);
    do_op("lhu", 1'b0, 1'b1, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0,
          32'h0000_2000, 32'h0, 4'b0000, 32'h0000_BEEF);
    do_op("lh",  1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1,
          32'h0000_2000, 32'h0, 4'b0000, 32'hFFFF_BEEF);
    do_op("sh",  1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'h1234_5678, 32'h5555_5555, 0,
          32'h0000_3000, 32'h5678_5678, 4'b1100, 32'hFFFF_BEEF);
    do_op("sb",  1'b1, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h0, 2,
          32'h0000_3000, 32'hABAB_ABAB, 4'b0010, 32'hFFFF_BEEF);
    do_op("sw",  1'b1, 1'b0, 3'b010, 32'h0000_400B, 32'hDEAD_BEEF, 32'h0, 5,
          32'h0000_4008, 32'hDEAD_BEEF, 4'b1111, 32'hFFFF_BEEF);
    @(posedge clock);
    @(negedge clock);
    done_cycle = 1'b0;
    chk("sw_single_done", 32'(mem_done), 32'h0);
    chk("sw_no_dup_req", 32'(bus_request), 32'h0);

    // Reset in the middle of an access: request dropped, late ack ignored.
    ex_valid = 1'b1;
    memory_read_enable = 1'b1;
    funct3 = 3'b010;
    alu_result = 32'h0000_7000;
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
    chk("rst_mid_req", 32'(bus_request), 32'h1);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_all_zero("rst_mid");
    reset_n = 1'b1;
    bus_ack = 1'b1;
    bus_read_data = 32'h1357_9BDF;
    @(posedge clock);
    @(negedge clock);
    chk("rst_late_ack_done", 32'(mem_done), 32'h0);
    chk("rst_late_ack_req", 32'(bus_request), 32'h0);
    chk("rst_late_ack_rdata", memory_read_data, 32'h0);
    bus_ack = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_late_ack_done2", 32'(mem_done), 32'h0);

    // Non-memory instruction: no stall, no request.
    ex_valid = 1'b1;
    alu_result = 32'h0000_0044;
    #1;
    chk("add_stall", 32'(ctrl_stall_flag), 32'h0);
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
    chk("add_req", 32'(bus_request), 32'h0);
    chk("add_done", 32'(mem_done), 32'h0);

    // Back-to-back loads: each following op is issued in the previous mem_done cycle.
    do_op("lw1", 1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'h0, 32'h1122_3344, 0,
          32'h0000_5004, 32'h0, 4'b0000, 32'h1122_3344);
    do_op("lw2", 1'b0, 1'b1, 3'b010, 32'h0000_5008, 32'h0, 32'hCAFE_F00D, 0,
          32'h0000_5008, 32'h0, 4'b0000, 32'hCAFE_F00D);
    do_op("lbu", 1'b0, 1'b1, 3'b100, 32'h0000_6001, 32'h0, 32'h0000_A500, 3,
          32'h0000_6000, 32'h0, 4'b0000, 32'h0000_00A5);
    do_op("lb2", 1'b0, 1'b1, 3'b000, 32'h0000_6002, 32'h0, 32'h0071_0000, 0,
          32'h0000_6000, 32'h0, 4'b0000, 32'h0000_0071);
    @(posedge clock);
    @(negedge clock);
    chk("end_done", 32'(mem_done), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
